// File: rtl/spi_mem_pkg.sv
// Shared opcodes, FSM state encoding and default sizing for the SPI memory controller.
package spi_mem_pkg;

  localparam int DEFAULT_ADDR_SIZE = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    RD_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/spi_mem_if.sv
// Parallel word interface between the SPI slave (master modport) and the memory controller (slave modport).
interface spi_mem_if;

  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       cmd_err;

  modport master (
    output rx_data, rx_valid,
    input  tx_data, tx_valid, cmd_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output tx_data, tx_valid, cmd_err
  );

endinterface

// File: rtl/spi_mem_ram.sv
// Single-port synchronous RAM: registered read, write-first, contents never reset.
module spi_mem_ram
  import spi_mem_pkg::*;
#(
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
  parameter int MEM_DEPTH = 2 ** ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [7:0]           din,
  output logic [7:0]           dout
);

  logic [7:0] mem [MEM_DEPTH];

  // A write also presents the new data on dout so a same-address read sees it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// Decodes 10-bit SPI words into RAM commands and returns read data.
// Optional SPI_MEM_AUTO_INC_EN: address registers post-increment after each write/read.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
  parameter int MEM_DEPTH = 2 ** ADDR_SIZE
) (
  input logic      clk,
  input logic      rst_n,
  spi_mem_if.slave bus
);

  state_t               state;
  state_t               next_state;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [7:0]           ram_dout;
  logic                 ram_we;
  logic                 cmd_accept;
  logic                 cmd_reject;
  logic                 load_tx;
  logic [1:0]           opcode;
  logic [ADDR_SIZE-1:0] payload_addr;
  logic [7:0]           payload;

  assign opcode       = bus.rx_data[9:8];
  assign payload      = bus.rx_data[7:0];
  assign payload_addr = bus.rx_data[ADDR_SIZE-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = (cmd_accept && opcode == CMD_RD_DATA) ? RD_WAIT : IDLE;
      RD_WAIT: next_state = RD_RESP;
      RD_RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Commands are only honoured in IDLE, so RAM writes and reads can never collide.
  always_comb begin
    cmd_accept   = bus.rx_valid && (state == IDLE);
    cmd_reject   = bus.rx_valid && (state != IDLE);
    ram_we       = cmd_accept && (opcode == CMD_WR_DATA);
    ram_addr     = ram_we ? wr_addr : rd_addr;
    load_tx      = (state == RD_WAIT);
    bus.tx_valid = (state == RD_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr     <= '0;
      rd_addr     <= '0;
      bus.tx_data <= '0;
      bus.cmd_err <= 1'b0;
    end else begin
      bus.cmd_err <= cmd_reject;
      if (load_tx) begin
        bus.tx_data <= ram_dout;
      end
      if (cmd_accept && opcode == CMD_WR_ADDR) begin
        wr_addr <= payload_addr;
      end
`ifdef SPI_MEM_AUTO_INC_EN
      else if (ram_we) begin
        wr_addr <= wr_addr + ADDR_SIZE'(1);
      end
`endif
      if (cmd_accept && opcode == CMD_RD_ADDR) begin
        rd_addr <= payload_addr;
      end
`ifdef SPI_MEM_AUTO_INC_EN
      else if (load_tx) begin
        rd_addr <= rd_addr + ADDR_SIZE'(1);
      end
`endif
    end
  end

  spi_mem_ram #(
    .ADDR_SIZE (ADDR_SIZE),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (payload),
    .dout (ram_dout)
  );

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl: directed scenarios plus random commands against a cycle-level reference model.
module tb_spi_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  spi_mem_if bus ();

  spi_mem_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef SPI_MEM_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  localparam bit [1:0] OP_WA = 2'b00;
  localparam bit [1:0] OP_WD = 2'b01;
  localparam bit [1:0] OP_RA = 2'b10;
  localparam bit [1:0] OP_RD = 2'b11;

  // Reference model: memory image, address pointers and the expected outputs after the next edge.
  bit [7:0] m_mem   [256];
  bit       m_known [256];
  int       m_wr;
  int       m_rd;
  int       m_busy;
  bit [7:0] m_pending;
  bit       m_pending_known;
  bit       exp_tx_valid;
  bit [7:0] exp_tx_data;
  bit       exp_tx_known;
  bit       exp_cmd_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic modelReset();
    m_wr         = 0;
    m_rd         = 0;
    m_busy       = 0;
    exp_tx_valid = 1'b0;
    exp_tx_data  = 8'h00;
    exp_tx_known = 1'b1;
    exp_cmd_err  = 1'b0;
  endtask

  task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".tx_valid"}, {7'd0, bus.tx_valid}, {7'd0, exp_tx_valid});
    checkValue({tag, ".cmd_err"}, {7'd0, bus.cmd_err}, {7'd0, exp_cmd_err});
    if (exp_tx_known) checkValue({tag, ".tx_data"}, bus.tx_data, exp_tx_data);
  endtask

  // Drives one cycle of input (called just after a falling edge), advances the model, checks at the next falling edge.
  task automatic applyStimulus(input bit v, input bit [1:0] op, input bit [7:0] pay, input string tag);
    bus.rx_valid = v;
    bus.rx_data  = {op, pay};
    exp_cmd_err  = v && (m_busy != 0);
    if (m_busy == 2) begin
      exp_tx_valid = 1'b1;
      exp_tx_data  = m_pending;
      exp_tx_known = m_pending_known;
      m_busy       = 1;
      if (AUTO_INC) m_rd = (m_rd + 1) % 256;
    end else if (m_busy == 1) begin
      exp_tx_valid = 1'b0;
      m_busy       = 0;
    end else begin
      exp_tx_valid = 1'b0;
      if (v) begin
        case (op)
          OP_WA: m_wr = pay;
          OP_WD: begin
            m_mem[m_wr]   = pay;
            m_known[m_wr] = 1'b1;
            if (AUTO_INC) m_wr = (m_wr + 1) % 256;
          end
          OP_RA: m_rd = pay;
          default: begin
            m_pending       = m_mem[m_rd];
            m_pending_known = m_known[m_rd];
            m_busy          = 2;
          end
        endcase
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 8'h00, tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    modelReset();
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset");
    rst_n = 1'b1;

    // Read with no prior RD_ADDR must come from address 0.
    applyStimulus(1'b1, OP_WD, 8'h3C, "wr0");
    applyStimulus(1'b1, OP_RD, 8'h00, "rd0_cmd");
    idle(2, "rd0");
    applyStimulus(1'b1, OP_WA, 8'h12, "basic_wa");
    applyStimulus(1'b1, OP_WD, 8'hA5, "basic_wd");
    applyStimulus(1'b1, OP_RA, 8'h12, "basic_ra");
    applyStimulus(1'b1, OP_RD, 8'h00, "basic_rd");
    idle(3, "basic_resp");

    for (int a = 0; a < 256; a++) begin
      applyStimulus(1'b1, OP_WA, 8'(a), "fill_wa");
      applyStimulus(1'b1, OP_WD, 8'($urandom), "fill_wd");
    end

    // Commands landing during a read are rejected and leave the pointers alone.
    applyStimulus(1'b1, OP_RA, 8'h40, "rej_ra");
    applyStimulus(1'b1, OP_RD, 8'h00, "rej_rd");
    applyStimulus(1'b1, OP_RA, 8'h55, "rej_wait");
    applyStimulus(1'b1, OP_WD, 8'hEE, "rej_resp");
    idle(1, "rej_idle");
    applyStimulus(1'b1, OP_RD, 8'h00, "rej_rd2");
    idle(3, "rej_resp2");

    applyStimulus(1'b1, OP_RA, 8'h12, "mid_ra");
    applyStimulus(1'b1, OP_RD, 8'h00, "mid_rd");
    #1 rst_n = 1'b0;
    #1 modelReset();
    checkOutput("mid_rst");
    @(negedge clk);
    checkOutput("mid_rst_hold1");
    @(negedge clk);
    checkOutput("mid_rst_hold2");
    rst_n = 1'b1;
    applyStimulus(1'b1, OP_RD, 8'h00, "post_rst_rd");
    idle(3, "post_rst_resp");

    applyStimulus(1'b1, OP_WA, 8'hFF, "wrap_wa");
    applyStimulus(1'b1, OP_WD, 8'h11, "wrap_wd1");
    applyStimulus(1'b1, OP_WD, 8'h22, "wrap_wd2");
    applyStimulus(1'b1, OP_RA, 8'hFF, "wrap_ra");
    applyStimulus(1'b1, OP_RD, 8'h00, "wrap_rd1");
    idle(2, "wrap_resp1");
    applyStimulus(1'b1, OP_RD, 8'h00, "wrap_rd2");
    idle(3, "wrap_resp2");

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom), "rand");
    end
    idle(3, "drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

Command controller between the SPI slave's parallel receive/transmit interface and an on-chip single-port RAM. It decodes each 10-bit word delivered by the slave (`rx_data`/`rx_valid`) into one of four memory commands. It holds the write and read address registers and sequences the synchronous RAM read. It returns read data to the slave on `tx_data`/`tx_valid` for shifting out on MISO.

## Interface
- `ADDR_SIZE`, default 8: address width, 1..8. Only `rx_data[ADDR_SIZE-1:0]` is used as an address.
- `MEM_DEPTH`, default 256: RAM depth, fixed as `2**ADDR_SIZE`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 10: `[9:8]` is the opcode, `[7:0]` is the payload, from the SPI slave.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in this cycle.
- `tx_data` out 8: read data to the SPI slave.
- `tx_valid` out 1: one-cycle strobe; `tx_data` is valid in this cycle.
- `cmd_err` out 1: one-cycle pulse when a command is rejected.

## Operation
- Opcodes, decoded only when `rx_valid`=1 in state IDLE:
  - `00` WR_ADDR: `wr_addr <= payload`.
  - `01` WR_DATA: `mem[wr_addr] <= payload`.
  - `10` RD_ADDR: `rd_addr <= payload`.
  - `11` RD_DATA: start a read of `mem[rd_addr]`; the payload is ignored.
- States:
  - IDLE: accepts commands. An RD_DATA command moves to RD_WAIT; all other commands stay in IDLE.
  - RD_WAIT: RAM output is being registered. Moves unconditionally to RD_RESP.
  - RD_RESP: `tx_valid`=1. Moves unconditionally to IDLE.
- `rx_valid`=1 while in RD_WAIT or RD_RESP: the command is dropped with no state or address change, and `cmd_err` pulses for one cycle.
- Writes and reads never occur in the same cycle, so the single port needs no arbitration.
- Address registers are `ADDR_SIZE` bits; payload bits above `ADDR_SIZE-1` are discarded.
- After reset, `wr_addr`=`rd_addr`=0. An RD_DATA with no prior RD_ADDR reads address 0.
- RAM contents are not reset and are undefined until written.
- `tx_data` holds the last read value until the next RD_RESP.
- Illegal state encodings recover to IDLE.

## Timing
- Reset values (asynchronous assert):
  - `tx_data`=0, `tx_valid`=0, `cmd_err`=0.
  - `wr_addr`=0, `rd_addr`=0.
  - state=IDLE.
- Write: command sampled at edge N; RAM updated at edge N. A read issued at edge N+1 returns the new value.
- Read: command sampled at edge N, and the RAM registers `mem[rd_addr]` at edge N.
  - `tx_data` is loaded and `tx_valid` rises at edge N+1.
  - `tx_valid` falls at edge N+2.
  - Latency is 2 edges; `tx_valid` is high for exactly 1 cycle.
- An RD_ADDR at edge N followed by RD_DATA at edge N+1 reads the new address.
- `cmd_err` asserts at the edge after the rejected `rx_valid` and is high for exactly 1 cycle.
- Reset asserted mid-read: `tx_valid` drops immediately, no response is produced, and the state returns to IDLE.
- Back-to-back legal commands, one per cycle in IDLE, are all accepted.

## Configuration
- `SPI_MEM_AUTO_INC_EN` defined:
  - After each accepted WR_DATA, `wr_addr` increments by 1.
  - At edge N+1 of each read, `rd_addr` increments by 1.
  - Both wrap from `MEM_DEPTH-1` to 0.
  - An explicit WR_ADDR/RD_ADDR always overrides the current value.
- Not defined: addresses change only via WR_ADDR/RD_ADDR; repeated WR_DATA overwrites the same location.

## Structure
- Package `spi_mem_pkg` holds:
  - opcode constants `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11;
  - the state encoding IDLE/RD_WAIT/RD_RESP;
  - the default `ADDR_SIZE`.
- Sub-module `spi_mem_ram`: single-port synchronous RAM with ports `clk`, `we`, `addr[ADDR_SIZE-1:0]`, `din[7:0]`, `dout[7:0]`. It has a registered read, write-first behaviour, and no reset.
- `spi_mem_ctrl` holds the FSM, address registers and output registers, and instantiates one `spi_mem_ram`.

## Test plan
- Reset, then WR_ADDR 0x12, WR_DATA 0xA5, RD_ADDR 0x12, RD_DATA → `tx_data`=0xA5 with `tx_valid` high for 1 cycle, 2 edges after the RD_DATA strobe.
- RD_DATA immediately after reset, after first writing 0x3C to address 0 → returns 0x3C, confirming `rd_addr` resets to 0.
- RD_DATA followed by any `rx_valid` on the next cycle → `cmd_err` pulses for 1 cycle; the second command has no effect and the read returns the correct data.
- Assert `rst_n`=0 during RD_WAIT → `tx_valid` is never asserted, all outputs are 0, and the next command is accepted normally.
- With `SPI_MEM_AUTO_INC_EN`: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22; then RD_ADDR 0xFF, RD_DATA, RD_DATA → reads 0x11 then 0x22 (address 0), confirming the wrap.
- Without the macro: the same write sequence, then read 0xFF → 0x22.
